// File: rtl/kmeans_iter_ctrl_if.sv
// Bus between the k-means iteration controller and its surroundings.
// Carries the frame/result handshake from the datapath and the current
// centroids plus control pulses back to it.
// master: the controller side; slave: the datapath/host side.
interface kmeans_iter_ctrl_if;
   logic       init_in;
   logic       frame_done_in;
   logic       valid_in;
   logic [8:0] c1_x_in;
   logic [7:0] c1_y_in;
   logic [8:0] c2_x_in;
   logic [7:0] c2_y_in;

   logic [8:0] c1_x_out;
   logic [7:0] c1_y_out;
   logic [8:0] c2_x_out;
   logic [7:0] c2_y_out;
   logic       start_out;
   logic       rst_coms_out;
   logic       update_out;
   logic       converged_out;
   logic       timeout_out;
   logic [7:0] iter_count_out;
   logic       busy_out;

   modport master (
      input  init_in, frame_done_in, valid_in,
      input  c1_x_in, c1_y_in, c2_x_in, c2_y_in,
      output c1_x_out, c1_y_out, c2_x_out, c2_y_out,
      output start_out, rst_coms_out, update_out,
      output converged_out, timeout_out, iter_count_out, busy_out
   );

   modport slave (
      output init_in, frame_done_in, valid_in,
      output c1_x_in, c1_y_in, c2_x_in, c2_y_in,
      input  c1_x_out, c1_y_out, c2_x_out, c2_y_out,
      input  start_out, rst_coms_out, update_out,
      input  converged_out, timeout_out, iter_count_out, busy_out
   );
endinterface

// File: rtl/kmeans_iter_ctrl.sv
// Iteration controller for the 2-cluster k-means datapath.
// Runs accumulate -> drain -> tabulate -> compare rounds until both
// centroids move by no more than THRESH (Manhattan) or MAX_ITER rounds
// have completed, then holds the final centroids.
// Optional macro KMEANS_SORT_EN: order the two new centroids so that
// centroid 1 is always the left-most (then upper-most) one.
module kmeans_iter_ctrl #(
   parameter logic [8:0] SEED1_X  = 9'd80,
   parameter logic [7:0] SEED1_Y  = 8'd60,
   parameter logic [8:0] SEED2_X  = 9'd240,
   parameter logic [7:0] SEED2_Y  = 8'd180,
   parameter logic [9:0] THRESH   = 10'd2,
   parameter int         MAX_ITER = 16,
   parameter int         DRAIN    = 3,
   parameter int         TIMEOUT  = 1024
) (
   input logic               clk_in,
   input logic               rst_in,
   kmeans_iter_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_WAIT,
      S_COMPARE,
      S_DONE
   } state_t;

   localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state_q, state_d;
   logic [DW-1:0] drain_cnt_q, drain_cnt_d;
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic [8:0]    c1_x_q, c1_x_d, c2_x_q, c2_x_d;
   logic [7:0]    c1_y_q, c1_y_d, c2_y_q, c2_y_d;
   logic [8:0]    new1_x_q, new1_x_d, new2_x_q, new2_x_d;
   logic [7:0]    new1_y_q, new1_y_d, new2_y_q, new2_y_d;
   logic          rst_coms_q, rst_coms_d;
   logic          update_q, update_d;
   logic          converged_q, converged_d;
   logic          timeout_q, timeout_d;
   logic [7:0]    iter_q, iter_d;

   logic [8:0]    p1_x, p2_x;
   logic [7:0]    p1_y, p2_y;
   logic [9:0]    d1, d2;
   logic [7:0]    iter_inc;

   function automatic logic [9:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
      return (a > b) ? {1'b0, a - b} : {1'b0, b - a};
   endfunction

   function automatic logic [9:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? {2'b00, a - b} : {2'b00, b - a};
   endfunction

   // Pair the captured result with centroid slots, swapping when ordering is enabled.
   always_comb begin
      p1_x = new1_x_q;
      p1_y = new1_y_q;
      p2_x = new2_x_q;
      p2_y = new2_y_q;
`ifdef KMEANS_SORT_EN
      if ((new1_x_q > new2_x_q) || ((new1_x_q == new2_x_q) && (new1_y_q > new2_y_q))) begin
         p1_x = new2_x_q;
         p1_y = new2_y_q;
         p2_x = new1_x_q;
         p2_y = new1_y_q;
      end
`endif
   end

   // Per-centroid Manhattan shift and the saturating next iteration count.
   always_comb begin
      d1       = abs_diff9(p1_x, c1_x_q) + abs_diff8(p1_y, c1_y_q);
      d2       = abs_diff9(p2_x, c2_x_q) + abs_diff8(p2_y, c2_y_q);
      iter_inc = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
   end

   // Next-state and register updates; init overrides whatever the FSM is doing.
   // The drain counter holds remaining cycles minus one so that start is
   // decoded directly from the last drain cycle.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      c1_x_d      = c1_x_q;
      c1_y_d      = c1_y_q;
      c2_x_d      = c2_x_q;
      c2_y_d      = c2_y_q;
      new1_x_d    = new1_x_q;
      new1_y_d    = new1_y_q;
      new2_x_d    = new2_x_q;
      new2_y_d    = new2_y_q;
      rst_coms_d  = 1'b0;
      update_d    = 1'b0;
      converged_d = converged_q;
      timeout_d   = timeout_q;
      iter_d      = iter_q;

      if (bus.init_in) begin
         c1_x_d      = SEED1_X;
         c1_y_d      = SEED1_Y;
         c2_x_d      = SEED2_X;
         c2_y_d      = SEED2_Y;
         iter_d      = 8'd0;
         converged_d = 1'b0;
         timeout_d   = 1'b0;
         rst_coms_d  = 1'b1;
         wait_cnt_d  = '0;
         state_d     = S_ACCUM;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
            end
            S_ACCUM: begin
               if (bus.frame_done_in) begin
                  drain_cnt_d = DW'(DRAIN - 1);
                  state_d     = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_cnt_q == '0) begin
                  wait_cnt_d = '0;
                  state_d    = S_WAIT;
               end else begin
                  drain_cnt_d = drain_cnt_q - DW'(1);
               end
            end
            S_WAIT: begin
               if (bus.valid_in) begin
                  new1_x_d = bus.c1_x_in;
                  new1_y_d = bus.c1_y_in;
                  new2_x_d = bus.c2_x_in;
                  new2_y_d = bus.c2_y_in;
                  state_d  = S_COMPARE;
               end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                  timeout_d  = 1'b1;
                  rst_coms_d = 1'b1;
                  state_d    = S_ACCUM;
               end else begin
                  wait_cnt_d = wait_cnt_q + TW'(1);
               end
            end
            S_COMPARE: begin
               c1_x_d   = p1_x;
               c1_y_d   = p1_y;
               c2_x_d   = p2_x;
               c2_y_d   = p2_y;
               update_d = 1'b1;
               iter_d   = iter_inc;
               if ((d1 <= THRESH) && (d2 <= THRESH)) begin
                  converged_d = 1'b1;
                  state_d     = S_DONE;
               end else if (iter_inc == 8'(MAX_ITER)) begin
                  state_d = S_DONE;
               end else begin
                  rst_coms_d = 1'b1;
                  state_d    = S_ACCUM;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, centroid and status registers with asynchronous reset to the seeds.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         wait_cnt_q  <= '0;
         c1_x_q      <= SEED1_X;
         c1_y_q      <= SEED1_Y;
         c2_x_q      <= SEED2_X;
         c2_y_q      <= SEED2_Y;
         new1_x_q    <= '0;
         new1_y_q    <= '0;
         new2_x_q    <= '0;
         new2_y_q    <= '0;
         rst_coms_q  <= 1'b0;
         update_q    <= 1'b0;
         converged_q <= 1'b0;
         timeout_q   <= 1'b0;
         iter_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         c1_x_q      <= c1_x_d;
         c1_y_q      <= c1_y_d;
         c2_x_q      <= c2_x_d;
         c2_y_q      <= c2_y_d;
         new1_x_q    <= new1_x_d;
         new1_y_q    <= new1_y_d;
         new2_x_q    <= new2_x_d;
         new2_y_q    <= new2_y_d;
         rst_coms_q  <= rst_coms_d;
         update_q    <= update_d;
         converged_q <= converged_d;
         timeout_q   <= timeout_d;
         iter_q      <= iter_d;
      end
   end

   assign bus.c1_x_out       = c1_x_q;
   assign bus.c1_y_out       = c1_y_q;
   assign bus.c2_x_out       = c2_x_q;
   assign bus.c2_y_out       = c2_y_q;
   assign bus.start_out      = (state_q == S_DRAIN) && (drain_cnt_q == '0);
   assign bus.rst_coms_out   = rst_coms_q;
   assign bus.update_out     = update_q;
   assign bus.converged_out  = converged_q;
   assign bus.timeout_out    = timeout_q;
   assign bus.iter_count_out = iter_q;
   assign bus.busy_out       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Self-checking bench for kmeans_iter_ctrl.
// A behavioural model tracks centroids, iteration count and status flags
// from plain arithmetic on each presented result; directed scenarios plus
// randomized results are compared against it with immediate assertions.
module tb_kmeans_iter_ctrl;

   localparam int SEED1_X_C  = 80;
   localparam int SEED1_Y_C  = 60;
   localparam int SEED2_X_C  = 240;
   localparam int SEED2_Y_C  = 180;
   localparam int THRESH_C   = 2;
   localparam int MAX_ITER_C = 16;
   localparam int DRAIN_C    = 3;
   localparam int TIMEOUT_C  = 1024;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;

   kmeans_iter_ctrl_if bus();

   kmeans_iter_ctrl #(
      .SEED1_X(9'(SEED1_X_C)),
      .SEED1_Y(8'(SEED1_Y_C)),
      .SEED2_X(9'(SEED2_X_C)),
      .SEED2_Y(8'(SEED2_Y_C)),
      .THRESH(10'(THRESH_C)),
      .MAX_ITER(MAX_ITER_C),
      .DRAIN(DRAIN_C),
      .TIMEOUT(TIMEOUT_C)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus(bus)
   );

   // Free-running 100 MHz clock.
   always #5 clk_in = ~clk_in;

   int compared   = 0;
   int mismatched = 0;

   int m_c1x, m_c1y, m_c2x, m_c2y, m_iter;
   bit m_conv, m_tout, m_done, m_busy;

   function automatic int absInt(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit init, input bit frame, input bit valid,
                                input int n1x, input int n1y, input int n2x, input int n2y);
      bus.init_in       = init;
      bus.frame_done_in = frame;
      bus.valid_in      = valid;
      bus.c1_x_in       = 9'(n1x);
      bus.c1_y_in       = 8'(n1y);
      bus.c2_x_in       = 9'(n2x);
      bus.c2_y_in       = 8'(n2y);
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic modelSeeds();
      m_c1x  = SEED1_X_C;
      m_c1y  = SEED1_Y_C;
      m_c2x  = SEED2_X_C;
      m_c2y  = SEED2_Y_C;
      m_iter = 0;
      m_conv = 1'b0;
      m_tout = 1'b0;
      m_done = 1'b0;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".c1x"}, 32'(bus.c1_x_out), 32'(m_c1x));
      checkOutput({tag, ".c1y"}, 32'(bus.c1_y_out), 32'(m_c1y));
      checkOutput({tag, ".c2x"}, 32'(bus.c2_x_out), 32'(m_c2x));
      checkOutput({tag, ".c2y"}, 32'(bus.c2_y_out), 32'(m_c2y));
      checkOutput({tag, ".iter"}, 32'(bus.iter_count_out), 32'(m_iter));
      checkOutput({tag, ".conv"}, 32'(bus.converged_out), 32'(m_conv));
      checkOutput({tag, ".tout"}, 32'(bus.timeout_out), 32'(m_tout));
      checkOutput({tag, ".busy"}, 32'(bus.busy_out), 32'(m_busy));
   endtask

   // Init pulse: seeds reloaded, one-cycle accumulator clear, iteration begins.
   task automatic doInit(input string tag);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
      tick();
      applyIdle();
      modelSeeds();
      m_busy = 1'b1;
      checkOutput({tag, ".rst_coms_hi"}, 32'(bus.rst_coms_out), 32'd1);
      checkModel(tag);
      tick();
      checkOutput({tag, ".rst_coms_lo"}, 32'(bus.rst_coms_out), 32'd0);
   endtask

   // Accumulate for a few cycles (stray valid_in ignored), then frame_done
   // and check the start pulse lands exactly DRAIN cycles later, one wide.
   // Returns one cycle after the start pulse, controller waiting for a result.
   task automatic doFrame(input string tag);
      int nAcc;
      nAcc = int'($urandom_range(1, 4));
      for (int i = 0; i < nAcc; i++) begin
         applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
         tick();
         checkOutput({tag, ".accum_update"}, 32'(bus.update_out), 32'd0);
         checkOutput({tag, ".accum_start"}, 32'(bus.start_out), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
      for (int k = 1; k <= DRAIN_C + 1; k++) begin
         checkOutput({tag, ".start"}, 32'(bus.start_out), 32'(k == DRAIN_C));
         if (k == 1) applyIdle();
         if (k <= DRAIN_C) tick();
      end
   endtask

   // Present one result after a random wait and check the commit against the model.
   task automatic doResult(input string tag, input int n1x, input int n1y, input int n2x, input int n2y);
      int nWait, p1x, p1y, p2x, p2y, d1, d2;
      nWait = int'($urandom_range(0, 3));
      for (int i = 0; i < nWait; i++) begin
         applyIdle();
         tick();
         checkOutput({tag, ".wait_update"}, 32'(bus.update_out), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, n1x, n1y, n2x, n2y);
      tick();
      applyIdle();
      checkOutput({tag, ".cmp_update"}, 32'(bus.update_out), 32'd0);
      checkModel({tag, ".cmp"});
      tick();

      p1x = n1x; p1y = n1y; p2x = n2x; p2y = n2y;
`ifdef KMEANS_SORT_EN
      if (n1x > n2x || (n1x == n2x && n1y > n2y)) begin
         p1x = n2x; p1y = n2y; p2x = n1x; p2y = n1y;
      end
`endif
      d1 = absInt(p1x - m_c1x) + absInt(p1y - m_c1y);
      d2 = absInt(p2x - m_c2x) + absInt(p2y - m_c2y);
      m_c1x = p1x; m_c1y = p1y; m_c2x = p2x; m_c2y = p2y;
      if (m_iter < 255) m_iter++;
      if (d1 <= THRESH_C && d2 <= THRESH_C) begin
         m_conv = 1'b1;
         m_done = 1'b1;
      end else if (m_iter == MAX_ITER_C) begin
         m_done = 1'b1;
      end
      m_busy = !m_done;

      checkOutput({tag, ".update_hi"}, 32'(bus.update_out), 32'd1);
      checkOutput({tag, ".rst_coms"}, 32'(bus.rst_coms_out), 32'(!m_done));
      checkModel({tag, ".post"});
      tick();
      checkOutput({tag, ".update_lo"}, 32'(bus.update_out), 32'd0);
      checkOutput({tag, ".rst_coms_lo"}, 32'(bus.rst_coms_out), 32'd0);
   endtask

   // Hard stop in case the design wedges somewhere unexpected.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios with randomized results, in order.
   initial begin
      int n1x, n1y, n2x, n2y, dx, sgn, nTicks;

      applyIdle();
      #2 rst_in = 1'b1;
      repeat (3) tick();
      modelSeeds();
      m_busy = 1'b0;
      checkModel("reset");
      checkOutput("reset.start", 32'(bus.start_out), 32'd0);
      checkOutput("reset.rst_coms", 32'(bus.rst_coms_out), 32'd0);
      checkOutput("reset.update", 32'(bus.update_out), 32'd0);
      rst_in = 1'b0;
      tick();

      $display("[TB] converging iteration");
      doInit("A.init");
      doFrame("A.frame");
      doResult("A.res", 81, 61, 240, 179);
      checkOutput("A.conv_const", 32'(bus.converged_out), 32'd1);
      checkOutput("A.iter_const", 32'(bus.iter_count_out), 32'd1);

      $display("[TB] inputs ignored while done");
      applyStimulus(1'b0, 1'b1, 1'b1, 5, 5, 6, 6);
      tick();
      applyIdle();
      for (int i = 0; i < DRAIN_C + 2; i++) begin
         tick();
         checkOutput("B.start", 32'(bus.start_out), 32'd0);
         checkOutput("B.update", 32'(bus.update_out), 32'd0);
      end
      checkModel("B.hold");

      $display("[TB] iteration cap");
      doInit("C.init");
      for (int i = 0; i < MAX_ITER_C; i++) begin
         if (m_done) break;
         sgn = (i % 2 == 0) ? 1 : -1;
         dx  = int'($urandom_range(0, 10));
         n1x = m_c1x + sgn * dx;
         n1y = m_c1y + sgn * (10 - dx);
         dx  = int'($urandom_range(0, 10));
         n2x = m_c2x - sgn * dx;
         n2y = m_c2y - sgn * (10 - dx);
         doFrame("C.frame");
         doResult("C.res", n1x, n1y, n2x, n2y);
      end
      checkOutput("C.iter_const", 32'(bus.iter_count_out), 32'd16);
      checkOutput("C.conv_const", 32'(bus.converged_out), 32'd0);
      checkOutput("C.busy_const", 32'(bus.busy_out), 32'd0);

      $display("[TB] wait timeout");
      doInit("D.init");
      doFrame("D.frame");
      nTicks = 1;
      while (bus.timeout_out !== 1'b1 && nTicks < TIMEOUT_C + 50) begin
         tick();
         nTicks++;
      end
      checkOutput("D.timeout_latency", 32'(nTicks), 32'(TIMEOUT_C + 1));
      m_tout = 1'b1;
      checkOutput("D.rst_coms", 32'(bus.rst_coms_out), 32'd1);
      checkModel("D.after");
      tick();
      checkOutput("D.rst_coms_lo", 32'(bus.rst_coms_out), 32'd0);
      doFrame("D.frame2");
      doResult("D.res", SEED1_X_C + 20, SEED1_Y_C, SEED2_X_C, SEED2_Y_C - 20);

      $display("[TB] init beats simultaneous valid");
      doFrame("E.frame");
      applyStimulus(1'b1, 1'b0, 1'b1, 100, 100, 200, 200);
      tick();
      applyIdle();
      modelSeeds();
      m_busy = 1'b1;
      checkOutput("E.rst_coms", 32'(bus.rst_coms_out), 32'd1);
      checkModel("E.init");
      tick();
      checkOutput("E.update", 32'(bus.update_out), 32'd0);
      checkModel("E.discard");

      $display("[TB] centroid ordering and random results");
      doFrame("F.frame");
      doResult("F.res", 300, 100, 50, 20);
`ifdef KMEANS_SORT_EN
      checkOutput("F.c1x_const", 32'(bus.c1_x_out), 32'd50);
`else
      checkOutput("F.c1x_const", 32'(bus.c1_x_out), 32'd300);
`endif
      for (int i = 0; i < 4; i++) begin
         if (m_done) break;
         doFrame("R.frame");
         doResult("R.res", int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
